// File: rtl/axis_code_mem_pkg.sv
// Shared types and helpers for the AXI-Stream code memory: loader FSM states
// and the predicate that decides when the code port may accept beats.
package axis_code_mem_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2,
        ST_ERR     = 2'd3
    } load_state_t;

    // The loader only takes beats while a program is being assembled.
    function automatic logic accepts_code(input load_state_t s);
        return (s == ST_EMPTY) || (s == ST_LOADING);
    endfunction

endpackage

// File: rtl/axis_code_mem_bram.sv
// Simple dual-port instruction memory: one write port, one registered read
// port with enable. The read register holds its value when not enabled.
module code_bram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port; contents survive reset so a reset never costs a reload.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; the output register alone is cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_code_mem.sv
// Instruction store for the AXI-Stream CPU. Programs arrive on the code
// stream, the loader FSM tracks completeness/overflow and keeps the CPU in
// reset until a whole program is present; the fetch port reads with 1-cycle
// latency, or 2 cycles when the optional output register is enabled.
module axis_code_mem
    import axis_code_mem_pkg::*;
#(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter bit PESS            = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 code_TDATA,
    input  logic                       code_TVALID,
    output logic                       code_TREADY,
    input  logic                       code_TLAST,
    input  logic                       reload_req,
    input  logic [CODE_ADDR_WIDTH-1:0] rd_addr,
    input  logic                       inst_rd_en,
    output logic [7:0]                 instr_out,
    output logic                       cpu_rst,
    output logic [CODE_ADDR_WIDTH:0]   prog_len,
    output logic                       load_err
);

    localparam logic [CODE_ADDR_WIDTH:0] PTR_ONE = {{CODE_ADDR_WIDTH{1'b0}}, 1'b1};

    load_state_t                r_state, w_state_next;
    logic [CODE_ADDR_WIDTH:0]   r_wr_ptr, w_wr_ptr_next;
    logic [CODE_ADDR_WIDTH:0]   r_prog_len, w_prog_len_next;
    logic                       r_load_err, w_load_err_next;
    logic                       w_accept;
    logic                       w_ptr_full;
    logic                       w_we;
    logic [CODE_ADDR_WIDTH-1:0] w_wr_addr;
    logic                       w_rd_en;
    logic [7:0]                 w_bram_dout;

    assign code_TREADY = ~rst & accepts_code(r_state);
    assign w_accept    = code_TVALID & code_TREADY;
    // wr_ptr never exceeds depth, so its MSB alone marks a full memory.
    assign w_ptr_full  = r_wr_ptr[CODE_ADDR_WIDTH];
    assign cpu_rst     = rst | (r_state != ST_READY);
    // Fetches are blocked while the CPU is held in reset, so reads and loader
    // writes never overlap.
    assign w_rd_en     = inst_rd_en & ~cpu_rst;
    assign prog_len    = r_prog_len;
    assign load_err    = r_load_err;

    // Loader state, write pointer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_wr_ptr   <= '0;
            r_prog_len <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_prog_len <= w_prog_len_next;
            r_load_err <= w_load_err_next;
        end
    end

    // Next-state logic; reload_req overrides everything, including a beat
    // accepted in the same cycle (that beat is dropped).
    always_comb begin
        w_state_next    = r_state;
        w_wr_ptr_next   = r_wr_ptr;
        w_prog_len_next = r_prog_len;
        w_load_err_next = r_load_err;
        w_we            = 1'b0;
        w_wr_addr       = r_wr_ptr[CODE_ADDR_WIDTH-1:0];
        if (reload_req) begin
            w_state_next    = ST_EMPTY;
            w_wr_ptr_next   = '0;
            w_load_err_next = 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_we          = 1'b1;
                        w_wr_addr     = '0;
                        w_wr_ptr_next = PTR_ONE;
                        if (code_TLAST) begin
                            w_state_next    = ST_READY;
                            w_prog_len_next = PTR_ONE;
                        end else begin
                            w_state_next = ST_LOADING;
                        end
                    end
                end
                ST_LOADING: begin
                    if (w_accept) begin
                        if (!w_ptr_full) begin
                            w_we          = 1'b1;
                            w_wr_ptr_next = r_wr_ptr + PTR_ONE;
                        end else begin
                            w_load_err_next = 1'b1;
                        end
                        if (code_TLAST) begin
                            w_prog_len_next = w_wr_ptr_next;
                            w_state_next    = w_load_err_next ? ST_ERR : ST_READY;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    code_bram #(
        .ADDR_WIDTH (CODE_ADDR_WIDTH),
        .DATA_WIDTH (8)
    ) u_code_bram (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (code_TDATA),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_bram_dout)
    );

    generate
        if (PESS) begin : g_pess
            logic       r_rd_en_d;
            logic [7:0] r_instr;
            // Second stage loads only behind a cycle in which the memory
            // register itself loaded, so stalls hold both stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_en_d <= 1'b0;
                    r_instr   <= '0;
                end else begin
                    r_rd_en_d <= w_rd_en;
                    if (r_rd_en_d) begin
                        r_instr <= w_bram_dout;
                    end
                end
            end
            assign instr_out = r_instr;
        end else begin : g_direct
            assign instr_out = w_bram_dout;
        end
    endgenerate

endmodule

// File: tb/tb_axis_code_mem.sv
// Directed bench for axis_code_mem: two instances (1-cycle and 2-cycle read
// latency, 8-word memory) share the same stimulus and are checked separately.
`timescale 1ns/1ps
module tb_axis_code_mem;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] code_TDATA = '0;
    logic       code_TVALID = 1'b0;
    logic       code_TLAST = 1'b0;
    logic       reload_req = 1'b0;
    logic [2:0] rd_addr = '0;
    logic       inst_rd_en = 1'b0;

    logic       tready0, cpu_rst0, load_err0;
    logic [7:0] instr0;
    logic [3:0] plen0;
    logic       tready1, cpu_rst1, load_err1;
    logic [7:0] instr1;
    logic [3:0] plen1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axis_code_mem #(.CODE_ADDR_WIDTH(3), .PESS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .code_TDATA(code_TDATA), .code_TVALID(code_TVALID),
        .code_TREADY(tready0), .code_TLAST(code_TLAST), .reload_req(reload_req),
        .rd_addr(rd_addr), .inst_rd_en(inst_rd_en), .instr_out(instr0),
        .cpu_rst(cpu_rst0), .prog_len(plen0), .load_err(load_err0)
    );

    axis_code_mem #(.CODE_ADDR_WIDTH(3), .PESS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .code_TDATA(code_TDATA), .code_TVALID(code_TVALID),
        .code_TREADY(tready1), .code_TLAST(code_TLAST), .reload_req(reload_req),
        .rd_addr(rd_addr), .inst_rd_en(inst_rd_en), .instr_out(instr1),
        .cpu_rst(cpu_rst1), .prog_len(plen1), .load_err(load_err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        code_TDATA  = d;
        code_TVALID = 1'b1;
        code_TLAST  = last;
        tick();
        code_TVALID = 1'b0;
        code_TLAST  = 1'b0;
    endtask

    task automatic pulse_reload();
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
    endtask

    // One enabled read cycle plus one idle cycle: both instances then show the word.
    task automatic do_read(input logic [2:0] a);
        rd_addr    = a;
        inst_rd_en = 1'b1;
        tick();
        inst_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_tests++; if (tready0 !== 1'b0 || tready1 !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b/%b expected 0", tready0, tready1); end
        n_tests++; if (cpu_rst0 !== 1'b1 || cpu_rst1 !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %b/%b expected 1", cpu_rst0, cpu_rst1); end
        rst = 1'b0;
        tick();
        n_tests++; if (tready0 !== 1'b1) begin n_fail++; $display("FAIL empty_tready: got %b expected 1", tready0); end
        n_tests++; if (plen0 !== 4'd0 || load_err0 !== 1'b0) begin n_fail++; $display("FAIL reset_status: got len=%0d err=%b expected len=0 err=0", plen0, load_err0); end
        n_tests++; if (instr0 !== 8'h00 || instr1 !== 8'h00) begin n_fail++; $display("FAIL reset_instr: got %h/%h expected 00", instr0, instr1); end
        $display("[TB] reset: cpu_rst=%b tready=%b", cpu_rst0, tready0);
    endtask

    task automatic test_load5();
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b0);
        n_tests++; if (cpu_rst0 !== 1'b1) begin n_fail++; $display("FAIL load5_mid_cpu_rst: got %b expected 1", cpu_rst0); end
        send(8'h15, 1'b1);
        n_tests++; if (cpu_rst0 !== 1'b0 || cpu_rst1 !== 1'b0) begin n_fail++; $display("FAIL load5_cpu_rst: got %b/%b expected 0", cpu_rst0, cpu_rst1); end
        n_tests++; if (plen0 !== 4'd5) begin n_fail++; $display("FAIL load5_len: got %0d expected 5", plen0); end
        n_tests++; if (tready0 !== 1'b0) begin n_fail++; $display("FAIL load5_ready_tready: got %b expected 0", tready0); end
        rd_addr = 3'd3; inst_rd_en = 1'b1;
        tick();
        inst_rd_en = 1'b0;
        n_tests++; if (instr0 !== 8'h14) begin n_fail++; $display("FAIL load5_rd_lat1: got %h expected 14", instr0); end
        n_tests++; if (instr1 !== 8'h00) begin n_fail++; $display("FAIL load5_pess_early: got %h expected 00", instr1); end
        tick();
        n_tests++; if (instr1 !== 8'h14) begin n_fail++; $display("FAIL load5_rd_lat2: got %h expected 14", instr1); end
        do_read(3'd0);
        n_tests++; if (instr0 !== 8'h11 || instr1 !== 8'h11) begin n_fail++; $display("FAIL load5_rd0: got %h/%h expected 11", instr0, instr1); end
        $display("[TB] load5: len=%0d instr=%h", plen0, instr0);
    endtask

    task automatic test_overflow();
        pulse_reload();
        n_tests++; if (cpu_rst0 !== 1'b1 || tready0 !== 1'b1) begin n_fail++; $display("FAIL reload_state: got cpu_rst=%b tready=%b expected 1/1", cpu_rst0, tready0); end
        n_tests++; if (plen0 !== 4'd5) begin n_fail++; $display("FAIL reload_len_kept: got %0d expected 5", plen0); end
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1'b0);
        n_tests++; if (load_err0 !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b expected 0", load_err0); end
        send(8'h28, 1'b0);
        n_tests++; if (load_err0 !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", load_err0); end
        send(8'h29, 1'b1);
        n_tests++; if (cpu_rst0 !== 1'b1 || tready0 !== 1'b0) begin n_fail++; $display("FAIL ovf_err_state: got cpu_rst=%b tready=%b expected 1/0", cpu_rst0, tready0); end
        n_tests++; if (plen0 !== 4'd8 || load_err1 !== 1'b1) begin n_fail++; $display("FAIL ovf_len: got len=%0d err=%b expected 8/1", plen0, load_err1); end
        do_read(3'd0);
        n_tests++; if (instr0 !== 8'h11) begin n_fail++; $display("FAIL ovf_read_blocked: got %h expected 11", instr0); end
        pulse_reload();
        n_tests++; if (load_err0 !== 1'b0) begin n_fail++; $display("FAIL ovf_reload_clear: got %b expected 0", load_err0); end
        send(8'h31, 1'b0);
        send(8'h32, 1'b1);
        n_tests++; if (cpu_rst0 !== 1'b0 || plen0 !== 4'd2) begin n_fail++; $display("FAIL ovf_recover: got cpu_rst=%b len=%0d expected 0/2", cpu_rst0, plen0); end
        do_read(3'd1);
        n_tests++; if (instr0 !== 8'h32) begin n_fail++; $display("FAIL ovf_rd1: got %h expected 32", instr0); end
        do_read(3'd7);
        n_tests++; if (instr0 !== 8'h27 || instr1 !== 8'h27) begin n_fail++; $display("FAIL ovf_stale7: got %h/%h expected 27", instr0, instr1); end
        $display("[TB] overflow: len=%0d err=%b", plen0, load_err0);
    endtask

    task automatic test_full();
        pulse_reload();
        for (int i = 0; i < 7; i++) send(8'h40 + 8'(i), 1'b0);
        send(8'h47, 1'b1);
        n_tests++; if (cpu_rst0 !== 1'b0 || load_err0 !== 1'b0) begin n_fail++; $display("FAIL full_state: got cpu_rst=%b err=%b expected 0/0", cpu_rst0, load_err0); end
        n_tests++; if (plen0 !== 4'd8) begin n_fail++; $display("FAIL full_len: got %0d expected 8", plen0); end
        do_read(3'd7);
        n_tests++; if (instr0 !== 8'h47) begin n_fail++; $display("FAIL full_rd7: got %h expected 47", instr0); end
        $display("[TB] full: len=%0d instr=%h", plen0, instr0);
    endtask

    task automatic test_single_beat();
        pulse_reload();
        code_TDATA = 8'hFF; code_TVALID = 1'b1; code_TLAST = 1'b1; reload_req = 1'b1;
        tick();
        code_TVALID = 1'b0; code_TLAST = 1'b0; reload_req = 1'b0;
        n_tests++; if (cpu_rst0 !== 1'b1 || tready0 !== 1'b1) begin n_fail++; $display("FAIL reload_wins: got cpu_rst=%b tready=%b expected 1/1", cpu_rst0, tready0); end
        send(8'hA5, 1'b1);
        n_tests++; if (cpu_rst0 !== 1'b0 || plen0 !== 4'd1) begin n_fail++; $display("FAIL single_state: got cpu_rst=%b len=%0d expected 0/1", cpu_rst0, plen0); end
        do_read(3'd0);
        n_tests++; if (instr0 !== 8'hA5 || instr1 !== 8'hA5) begin n_fail++; $display("FAIL single_rd0: got %h/%h expected a5", instr0, instr1); end
        $display("[TB] single: len=%0d instr=%h", plen0, instr0);
    endtask

    task automatic test_rst_mid_load();
        pulse_reload();
        for (int i = 0; i < 3; i++) send(8'h50 + 8'(i), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_tests++; if (cpu_rst0 !== 1'b1 || tready0 !== 1'b1 || plen0 !== 4'd0) begin n_fail++; $display("FAIL rstmid_empty: got cpu_rst=%b tready=%b len=%0d expected 1/1/0", cpu_rst0, tready0, plen0); end
        for (int i = 0; i < 3; i++) send(8'h61 + 8'(i), 1'b0);
        send(8'h64, 1'b1);
        n_tests++; if (cpu_rst0 !== 1'b0 || plen0 !== 4'd4) begin n_fail++; $display("FAIL rstmid_len: got cpu_rst=%b len=%0d expected 0/4", cpu_rst0, plen0); end
        do_read(3'd2);
        n_tests++; if (instr0 !== 8'h63) begin n_fail++; $display("FAIL rstmid_rd2: got %h expected 63", instr0); end
        do_read(3'd3);
        n_tests++; if (instr0 !== 8'h64 || instr1 !== 8'h64) begin n_fail++; $display("FAIL rstmid_rd3: got %h/%h expected 64", instr0, instr1); end
        $display("[TB] rst_mid_load: len=%0d", plen0);
    endtask

    task automatic test_alternate();
        logic       en_v [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0] adr_v [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
        logic [7:0] e0 [6]    = '{8'h61, 8'h61, 8'h62, 8'h62, 8'h63, 8'h63};
        logic [7:0] e1 [6]    = '{8'h64, 8'h61, 8'h61, 8'h62, 8'h62, 8'h63};
        code_TDATA = 8'hEE; code_TVALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            inst_rd_en = en_v[i];
            rd_addr    = adr_v[i];
            tick();
            n_tests++; if (instr0 !== e0[i]) begin n_fail++; $display("FAIL alt_lat1_%0d: got %h expected %h", i, instr0, e0[i]); end
            n_tests++; if (instr1 !== e1[i]) begin n_fail++; $display("FAIL alt_lat2_%0d: got %h expected %h", i, instr1, e1[i]); end
            n_tests++; if (tready0 !== 1'b0) begin n_fail++; $display("FAIL alt_tready_%0d: got %b expected 0", i, tready0); end
            $display("[TB] alt step %0d: en=%b addr=%0d instr=%h/%h", i, en_v[i], adr_v[i], instr0, instr1);
        end
        code_TVALID = 1'b0; inst_rd_en = 1'b0;
        do_read(3'd0);
        n_tests++; if (instr0 !== 8'h61 || plen0 !== 4'd4) begin n_fail++; $display("FAIL alt_no_write: got %h len=%0d expected 61/4", instr0, plen0); end
    endtask

    initial begin
        test_reset();
        test_load5();
        test_overflow();
        test_full();
        test_single_beat();
        test_rst_mid_load();
        test_alternate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_code_mem.md
Name: axis_code_mem

Overview:
- Instruction store for the AXI-Stream CPU; sits directly upstream of the controller.
- Holds the BPF-style program as 8-bit instruction words.
- Serves the fetch stage's read requests (inst_rd_en + PC address) with fixed latency onto the controller's instruction input.
- Loads programs from an AXI-Stream code port through a small FSM, and holds the CPU in reset until a complete program is present.

Parameters:
- CODE_ADDR_WIDTH, 10: address width; depth = 2**CODE_ADDR_WIDTH words.
- PESS, 0: 1 adds an output register, giving 2-cycle read latency. This pairs with the controller's idle-stage build.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- code_TDATA  in  8  instruction word being loaded.
- code_TVALID  in  1  loader beat valid.
- code_TREADY  out  1  loader beat accepted when high with TVALID.
- code_TLAST  in  1  final word of program.
- reload_req  in  1  single-cycle pulse; discard the current program and accept a new one.
- rd_addr  in  CODE_ADDR_WIDTH  fetch address (PC) from the datapath.
- inst_rd_en  in  1  fetch enable from the controller.
- instr_out  out  8  fetched instruction, to the controller's instruction input.
- cpu_rst  out  1  high whenever no valid program is present; drives the CPU reset.
- prog_len  out  CODE_ADDR_WIDTH+1  number of words written by the last load.
- load_err  out  1  sticky flag: the last load overflowed the memory.

Behaviour:
- Reset values: state=EMPTY, wr_ptr=0, prog_len=0, load_err=0, instr_out=0, cpu_rst=1, code_TREADY=0 during the reset cycle.
- code_TREADY=1 in EMPTY and LOADING only. cpu_rst=1 in every state except READY.
- FSM states: EMPTY, LOADING, READY, ERR.
- EMPTY:
  - Accepted beat writes mem[0] and sets wr_ptr=1.
  - With TLAST on that beat: go to READY, prog_len=1.
  - Without TLAST: go to LOADING.
- LOADING:
  - Each accepted beat with wr_ptr < depth writes mem[wr_ptr] and increments wr_ptr.
  - An accepted beat with wr_ptr == depth (memory full) is discarded and sets load_err=1. wr_ptr does not wrap.
  - Accepted TLAST: go to READY if load_err=0, else ERR. prog_len=wr_ptr after the beat.
  - A full program of exactly depth words ending in TLAST goes to READY, prog_len=depth, load_err=0.
- READY:
  - code_TREADY=0.
  - Stays until reload_req.
- ERR:
  - code_TREADY=0, cpu_rst=1.
  - Exits only on reload_req.
- reload_req in any state: next state EMPTY, wr_ptr=0, load_err=0, prog_len unchanged until the next TLAST. reload_req wins over a simultaneous accepted beat: that beat is accepted and discarded.
- rst mid-load: abandon the load, return to EMPTY. Memory contents are not cleared.
- Read port:
  - PESS=0: inst_rd_en high at cycle N latches mem[rd_addr] into instr_out at N+1.
  - PESS=1: the word is captured at N+1 and appears on instr_out at N+2. The second register loads only when the first register loaded in the previous cycle.
  - With inst_rd_en low, instr_out holds its value (no bubble). This is required by the stage1 stall scheme.
- Reads are ignored while cpu_rst=1 (instr_out holds), so a read never overlaps a write.
- Reading an address >= prog_len returns stale memory contents; the memory does not check range.

Decomposition:
- FSM state encodings and the loader constants (depth derived from CODE_ADDR_WIDTH) go into axis_cpu_defs.vh next to the PC_SEL codes.
- One sub-module, code_bram: simple dual-port memory (1 write port, 1 registered read port with enable), inferable as BRAM.
- The FSM, counters and the optional PESS register stay in axis_code_mem.

Test Plan:
- Load 5 words 0x11..0x15 with TLAST on the 5th.
  - Expected: cpu_rst falls the cycle after the TLAST beat, prog_len=5.
  - Then inst_rd_en=1 with rd_addr=3 gives instr_out=0x14 one cycle later (PESS=0), or two cycles later (PESS=1).
- CODE_ADDR_WIDTH=3, load 10 words ending in TLAST.
  - Expected: words 0..7 are stored, load_err=1, state ERR, cpu_rst stays 1.
  - Then reload_req followed by a 2-word load clears load_err and gives READY with prog_len=2.
- Single-beat program (TLAST on beat 0, data 0xA5).
  - Expected: READY directly from EMPTY, prog_len=1, mem[0]=0xA5.
- Assert rst after 3 of 6 beats, then send a full 4-word program.
  - Expected: EMPTY after reset, and the new program's contents/prog_len=4 are correct.
- In READY, alternate inst_rd_en 1/0 over addresses 0,1,2.
  - Expected: instr_out updates only after enabled cycles and holds otherwise. code_TREADY stays 0 while TVALID is held high.
